// File: rtl/key_pulse_gen.sv
// Key front-end: synchronises and debounces two push-buttons, then turns the
// debounced levels into single-cycle add/sub command pulses with optional auto-repeat.
module key_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000,
  parameter bit REPEAT_EN       = 1'b1,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_add_in,
  input  logic       key_sub_in,
  output logic       key_add,
  output logic       key_sub,
  output logic [1:0] key_level
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX);

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [1:0]       RAW_IDLE    = KEY_ACTIVE_LOW ? 2'b11 : 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    ADD_HELD,
    ADD_RPT,
    SUB_HELD,
    SUB_RPT,
    LOCK
  } state_t;

  logic [1:0]            r_sync1;
  logic [1:0]            r_sync2;
  logic [1:0]            r_db;
  logic [1:0][DB_W-1:0]  r_dbCnt;
  logic [1:0]            w_lvl;

  state_t                r_state;
  state_t                w_nextState;
  logic [RPT_W-1:0]      r_rptCnt;
  logic [RPT_W-1:0]      w_rptNext;
  logic                  r_keyAdd;
  logic                  r_keySub;
  logic                  w_addNext;
  logic                  w_subNext;
  logic                  w_addHeld;
  logic                  w_subHeld;

  // Index 0 is the add key, index 1 the sub key; level is 1 = pressed.
  assign w_lvl = KEY_ACTIVE_LOW ? ~r_sync2 : r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= RAW_IDLE;
      r_sync2 <= RAW_IDLE;
      r_db    <= 2'b00;
      r_dbCnt <= '0;
    end else begin
      r_sync1 <= {key_sub_in, key_add_in};
      r_sync2 <= r_sync1;
      for (int k = 0; k < 2; k++) begin
        if (w_lvl[k] == r_db[k]) begin
          r_dbCnt[k] <= '0;
        end else if (r_dbCnt[k] == DB_LAST) begin
          r_db[k]    <= ~r_db[k];
          r_dbCnt[k] <= '0;
        end else begin
          r_dbCnt[k] <= r_dbCnt[k] + DB_W'(1);
        end
      end
    end
  end

  assign w_addHeld = r_db[0];
  assign w_subHeld = r_db[1];

  // Own-key release is tested before other-key press so release wins a tie.
  always_comb begin
    w_nextState = r_state;
    w_rptNext   = '0;
    w_addNext   = 1'b0;
    w_subNext   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_addHeld && w_subHeld) begin
          w_nextState = LOCK;
        end else if (w_addHeld) begin
          w_nextState = ADD_HELD;
          w_addNext   = 1'b1;
        end else if (w_subHeld) begin
          w_nextState = SUB_HELD;
          w_subNext   = 1'b1;
        end
      end
      ADD_HELD, ADD_RPT: begin
        if (!w_addHeld) begin
          w_nextState = IDLE;
        end else if (w_subHeld) begin
          w_nextState = LOCK;
        end else if (REPEAT_EN) begin
          if (r_rptCnt == ((r_state == ADD_HELD) ? DELAY_LAST : PERIOD_LAST)) begin
            w_nextState = ADD_RPT;
            w_addNext   = 1'b1;
          end else begin
            w_rptNext = r_rptCnt + RPT_W'(1);
          end
        end
      end
      SUB_HELD, SUB_RPT: begin
        if (!w_subHeld) begin
          w_nextState = IDLE;
        end else if (w_addHeld) begin
          w_nextState = LOCK;
        end else if (REPEAT_EN) begin
          if (r_rptCnt == ((r_state == SUB_HELD) ? DELAY_LAST : PERIOD_LAST)) begin
            w_nextState = SUB_RPT;
            w_subNext   = 1'b1;
          end else begin
            w_rptNext = r_rptCnt + RPT_W'(1);
          end
        end
      end
      LOCK: begin
        if (!w_addHeld && !w_subHeld) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rptCnt <= '0;
      r_keyAdd <= 1'b0;
      r_keySub <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_rptCnt <= w_rptNext;
      r_keyAdd <= w_addNext;
      r_keySub <= w_subNext;
    end
  end

  assign key_add   = r_keyAdd;
  assign key_sub   = r_keySub;
  assign key_level = r_db;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Self-checking bench for key_pulse_gen: one instance with auto-repeat, one without,
// both fed the same pins and compared against scoreboard queues of expected events.
module tb_key_pulse_gen;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       keyAddIn;
  logic       keySubIn;
  logic       keyAddA, keySubA, keyAddB, keySubB;
  logic [1:0] levelA, levelB;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  expLevel = 0;
  bit  monEn = 1'b0;
  ev_t pqA[$];
  ev_t pqB[$];
  ev_t lq[$];

  key_pulse_gen #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .REPEAT_EN(1'b1), .KEY_ACTIVE_LOW(1'b1)
  ) dutA (
    .clk(clk), .rst(rst), .key_add_in(keyAddIn), .key_sub_in(keySubIn),
    .key_add(keyAddA), .key_sub(keySubA), .key_level(levelA)
  );

  key_pulse_gen #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .REPEAT_EN(1'b0), .KEY_ACTIVE_LOW(1'b1)
  ) dutB (
    .clk(clk), .rst(rst), .key_add_in(keyAddIn), .key_sub_in(keySubIn),
    .key_add(keyAddB), .key_sub(keySubB), .key_level(levelB)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // which: 0 = repeat-instance pulses, 1 = no-repeat pulses, 2 = level changes
  task automatic addEv(input int which, input int c, input int v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    case (which)
      0: pqA.push_back(e);
      1: pqB.push_back(e);
      default: lq.push_back(e);
    endcase
  endtask

  task automatic applyStimulus(input bit addPressed, input bit subPressed);
    keyAddIn = ~addPressed;
    keySubIn = ~subPressed;
  endtask

  task automatic stepTo(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected events for one key pressed at pressAt and released at relAt, other key idle.
  task automatic expectPress(input int t0, input int pressAt, input int relAt, input bit isSub);
    int base;
    int rel;
    int v;
    int p;
    base = t0 + pressAt;
    rel  = t0 + relAt;
    v    = isSub ? 2 : 1;
    addEv(2, base + DB + 2, v);
    addEv(0, base + DB + 3, v);
    addEv(1, base + DB + 3, v);
    p = base + DB + 3 + RD;
    while (p <= rel + DB + 2) begin
      addEv(0, p, v);
      p += RP;
    end
    addEv(2, rel + DB + 2, 0);
  endtask

  task automatic finishScenario(input string tag);
    checkOutput({tag, "_pendA"}, pqA.size(), 0);
    checkOutput({tag, "_pendB"}, pqB.size(), 0);
    checkOutput({tag, "_pendLvl"}, lq.size(), 0);
    pqA.delete();
    pqB.delete();
    lq.delete();
  endtask

  always @(negedge clk) begin
    if (monEn) begin
      if (pqA.size() > 0 && pqA[0].cyc == cyc) begin
        checkOutput("pulseA", int'({keySubA, keyAddA}), pqA[0].val);
        void'(pqA.pop_front());
      end else if ({keySubA, keyAddA} != 2'b00) begin
        checkOutput("spuriousA", int'({keySubA, keyAddA}), 0);
      end
      if (pqB.size() > 0 && pqB[0].cyc == cyc) begin
        checkOutput("pulseB", int'({keySubB, keyAddB}), pqB[0].val);
        void'(pqB.pop_front());
      end else if ({keySubB, keyAddB} != 2'b00) begin
        checkOutput("spuriousB", int'({keySubB, keyAddB}), 0);
      end
      while (lq.size() > 0 && lq[0].cyc <= cyc) begin
        expLevel = lq[0].val;
        void'(lq.pop_front());
      end
      checkOutput("levelA", int'(levelA), expLevel);
      checkOutput("levelB", int'(levelB), expLevel);
    end
  end

  initial begin
    int t0;
    int r0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstAdd", int'(keyAddA), 0);
    checkOutput("rstSub", int'(keySubA), 0);
    checkOutput("rstLevel", int'(levelA), 0);
    rst = 1'b0;
    expLevel = 0;
    monEn = 1'b1;
    $display("[TB] idle after reset");
    stepTo(cyc + 100);
    finishScenario("idle");

    $display("[TB] add held 15 cycles");
    t0 = cyc;
    expectPress(t0, 0, 15, 1'b0);
    applyStimulus(1'b1, 1'b0);
    stepTo(t0 + 15);
    applyStimulus(1'b0, 1'b0);
    stepTo(t0 + 40);
    finishScenario("hold15");

    $display("[TB] add held exactly debounce length");
    t0 = cyc;
    expectPress(t0, 0, DB, 1'b0);
    applyStimulus(1'b1, 1'b0);
    stepTo(t0 + DB);
    applyStimulus(1'b0, 1'b0);
    stepTo(t0 + 30);
    finishScenario("holdMin");

    $display("[TB] sub glitches");
    t0 = cyc;
    for (int g = 0; g < 10; g++) begin
      applyStimulus(1'b0, 1'b1);
      stepTo(t0 + g * 8 + 3);
      applyStimulus(1'b0, 1'b0);
      stepTo(t0 + g * 8 + 8);
    end
    stepTo(t0 + 100);
    finishScenario("glitch");

    $display("[TB] add held 60 cycles");
    t0 = cyc;
    expectPress(t0, 0, 60, 1'b0);
    applyStimulus(1'b1, 1'b0);
    stepTo(t0 + 60);
    applyStimulus(1'b0, 1'b0);
    stepTo(t0 + 80);
    finishScenario("hold60");

    $display("[TB] sub held 40 cycles");
    t0 = cyc;
    expectPress(t0, 0, 40, 1'b1);
    applyStimulus(1'b0, 1'b1);
    stepTo(t0 + 40);
    applyStimulus(1'b0, 1'b0);
    stepTo(t0 + 60);
    finishScenario("subHold");

    $display("[TB] both pressed together");
    t0 = cyc;
    addEv(2, t0 + DB + 2, 3);
    addEv(2, t0 + 20 + DB + 2, 0);
    applyStimulus(1'b1, 1'b1);
    stepTo(t0 + 20);
    applyStimulus(1'b0, 1'b0);
    stepTo(t0 + 40);
    finishScenario("both");

    $display("[TB] add then sub lockout");
    t0 = cyc;
    addEv(2, t0 + DB + 2, 1);
    addEv(0, t0 + DB + 3, 1);
    addEv(1, t0 + DB + 3, 1);
    addEv(2, t0 + 12 + DB + 2, 3);
    addEv(2, t0 + 30 + DB + 2, 2);
    addEv(2, t0 + 40 + DB + 2, 0);
    addEv(2, t0 + 60 + DB + 2, 2);
    addEv(0, t0 + 60 + DB + 3, 2);
    addEv(1, t0 + 60 + DB + 3, 2);
    addEv(2, t0 + 70 + DB + 2, 0);
    applyStimulus(1'b1, 1'b0);
    stepTo(t0 + 12);
    applyStimulus(1'b1, 1'b1);
    stepTo(t0 + 30);
    applyStimulus(1'b0, 1'b1);
    stepTo(t0 + 40);
    applyStimulus(1'b0, 1'b0);
    stepTo(t0 + 60);
    applyStimulus(1'b0, 1'b1);
    stepTo(t0 + 70);
    applyStimulus(1'b0, 1'b0);
    stepTo(t0 + 100);
    finishScenario("lock");

    $display("[TB] reset during hold");
    t0 = cyc;
    addEv(2, t0 + DB + 2, 1);
    addEv(0, t0 + DB + 3, 1);
    addEv(1, t0 + DB + 3, 1);
    addEv(0, t0 + DB + 3 + RD, 1);
    applyStimulus(1'b1, 1'b0);
    stepTo(t0 + DB + 3 + RD + RP - 1);
    finishScenario("preRst");
    stepTo(t0 + DB + 3 + RD + RP);
    monEn = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midRstAdd", int'(keyAddA), 0);
    checkOutput("midRstLevel", int'(levelA), 0);
    checkOutput("midRstLevelB", int'(levelB), 0);
    stepTo(cyc + 3);
    rst = 1'b0;
    r0 = cyc;
    expLevel = 0;
    expectPress(r0, 0, 40, 1'b0);
    monEn = 1'b1;
    stepTo(r0 + 40);
    applyStimulus(1'b0, 1'b0);
    stepTo(r0 + 60);
    finishScenario("postRst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
